// File: rtl/fetch_queue_unit.sv
// fetch_queue_unit: instruction prefetch queue.
// A fetch PC drives a combinational instruction memory. Each fetched
// {pc, instr} pair is pushed into a circular buffer that feeds decode.
// Redirects flush the queue and restart fetch at an aligned target.
//
// Handshake: the head entry transfers to decode on a rising edge where
// out_valid and out_ready are both high. out_valid does not depend on
// out_ready, and the queue never withdraws a presented entry except on
// redirect or reset.
module fetch_queue_unit #(
  parameter int              XLEN      = 32,
  parameter int              DEPTH     = 4,
  parameter logic [XLEN-1:0] RESET_PC  = 32'h0000_0000,
  parameter logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     redirect_valid,
  input  logic [XLEN-1:0]          redirect_pc,
  input  logic                     kill,
  output logic [XLEN-1:0]          imem_addr,
  input  logic [XLEN-1:0]          imem_rdata,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [XLEN-1:0]          out_instr,
  output logic [XLEN-1:0]          out_pc,
  output logic [$clog2(DEPTH):0]   occupancy
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  logic [XLEN-1:0] fpc_q, fpc_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]   count_q, count_d;

  // Entry storage; contents are only meaningful below count_q, so no reset.
  logic [XLEN-1:0] pc_mem_q    [DEPTH];
  logic [XLEN-1:0] instr_mem_q [DEPTH];

  logic full;
  logic push;
  logic pop;

  // Handshake qualifiers; redirect suppresses both push and pop.
  always_comb begin
    full      = (count_q == DEPTH_C);
    out_valid = (count_q != '0) && !redirect_valid;
    pop       = out_valid && out_ready;
    push      = !redirect_valid && (!full || pop);
  end

  // Next-state for fetch PC, pointers and occupancy count.
  always_comb begin
    fpc_d    = fpc_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (redirect_valid) begin
      fpc_d    = {redirect_pc[XLEN-1:2], 2'b00};
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        fpc_d    = fpc_q + XLEN'(4);
        wr_ptr_d = wr_ptr_q + PW'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PW'(1);
      end
      if (push && !pop) begin
        count_d = count_q + CW'(1);
      end else if (pop && !push) begin
        count_d = count_q - CW'(1);
      end
    end
  end

  // Control state with asynchronous reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fpc_q    <= RESET_PC;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      fpc_q    <= fpc_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Write the fetched pair into the tail slot on push.
  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem_q[wr_ptr_q]    <= fpc_q;
      instr_mem_q[wr_ptr_q] <= imem_rdata;
    end
  end

  // Head presentation; kill only masks the instruction word.
  always_comb begin
    imem_addr = fpc_q;
    occupancy = count_q;
    out_pc    = pc_mem_q[rd_ptr_q];
    out_instr = kill ? NOP_INSTR : instr_mem_q[rd_ptr_q];
  end

endmodule
